// File: rtl/edge_fetch_ctrl_pkg.sv
// Shared definitions for the edge fetch controller: parameter defaults, FSM
// encoding and the layout of an offset-table word.
package edge_fetch_ctrl_pkg;

  localparam int DEF_NODE_IDX_WIDTH  = 10;
  localparam int DEF_COUNTER_WIDTH   = 4;
  localparam int DEF_EDGE_ADDR_WIDTH = 12;

  // Offset word is {edge_base, edge_cnt}: edge_cnt in the low bits,
  // edge_base packed directly above it.
  localparam int OFS_CNT_LSB = 0;

  function automatic int ofs_base_lsb(input int cnt_width);
    return OFS_CNT_LSB + cnt_width;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/edge_fetch_ctrl_skid_buf.sv
// Two-entry in-order buffer between the edge memory read port and the
// neighbour stream; exposes occupancy so the issuer never overruns it.
module edge_skid_buf #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       occ_q;

  // NOTE: the storage entries are reset too -- only two words, and it keeps the
  // head value (and thus the outputs) at a defined zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign valid = (occ_q != 2'd0);
  assign occ   = occ_q;

endmodule

// File: rtl/edge_fetch_ctrl.sv
// Fetches the out-edge list of one node: reads {base, count} from the offset
// table, then streams neighbour indices from edge memory with backpressure.
module edge_fetch_ctrl
  import edge_fetch_ctrl_pkg::*;
#(
  parameter int PARAM_NODE_IDX_WIDTH  = DEF_NODE_IDX_WIDTH,
  parameter int PARAM_COUNTER_WIDTH   = DEF_COUNTER_WIDTH,
  parameter int PARAM_EDGE_ADDR_WIDTH = DEF_EDGE_ADDR_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]                req_node_idx,
  input  logic                                           abort,
  output logic                                           ofs_rd_en,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]                ofs_addr,
  input  logic [PARAM_EDGE_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] ofs_rd_data,
  output logic                                           edge_rd_en,
  output logic [PARAM_EDGE_ADDR_WIDTH-1:0]               edge_addr,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]                edge_rd_data,
  output logic                                           edge_valid,
  input  logic                                           edge_ready,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]                edge_node_idx,
  output logic                                           edge_last,
  output logic [PARAM_COUNTER_WIDTH-1:0]                 edge_count,
  output logic                                           done
);

  localparam int NW       = PARAM_NODE_IDX_WIDTH;
  localparam int CW       = PARAM_COUNTER_WIDTH;
  localparam int AW       = PARAM_EDGE_ADDR_WIDTH;
  localparam int CW1      = CW + 1;
  localparam int BASE_LSB = ofs_base_lsb(CW);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] issued_q;
  logic          inflight_q;
  logic          inflight_last_q;

  logic          handshake;
  logic          pop;
  logic          push;
  logic          flush;
  logic          issue;
  logic          issue_last;
  logic          buf_valid;
  logic [NW:0]   buf_dout;
  logic [1:0]    occ;
  logic [1:0]    occ_after;
  logic [1:0]    load_sum;

  // Gated by rst_n so the offset strobe stays low while reset is held.
  assign handshake = rst_n && (state_q == ST_IDLE) && req_valid;
  assign req_ready = (state_q == ST_IDLE);
  assign ofs_rd_en = handshake;
  assign ofs_addr  = handshake ? req_node_idx : '0;

  assign pop   = buf_valid && edge_ready;
  assign flush = abort && (state_q != ST_IDLE);
  assign push  = inflight_q && !abort;

  // Credit check counts this cycle's pop so a drained slot is refilled at once,
  // giving one neighbour per cycle when the consumer never stalls.
  assign occ_after  = occ - 2'(pop);
  assign load_sum   = occ_after + 2'(inflight_q);
  assign issue      = (state_q == ST_STREAM) && !abort &&
                      (issued_q < cnt_q) && (load_sum < 2'd2);
  assign issue_last = (CW1'(issued_q) + CW1'(1)) == CW1'(cnt_q);

  assign edge_rd_en = issue;
  assign edge_addr  = base_q + AW'(issued_q);

  edge_skid_buf #(
    .WIDTH (NW + 1)
  ) u_skid_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({inflight_last_q, edge_rd_data}),
    .pop   (pop),
    .flush (flush),
    .dout  (buf_dout),
    .valid (buf_valid),
    .occ   (occ)
  );

  assign edge_valid    = buf_valid;
  assign edge_node_idx = buf_valid ? buf_dout[NW-1:0] : '0;
  assign edge_last     = buf_valid && buf_dout[NW];
  assign edge_count    = cnt_q;
  assign done          = (state_q == ST_DONE) && !abort;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      cnt_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LOAD) begin
        base_q   <= ofs_rd_data[BASE_LSB +: AW];
        cnt_q    <= ofs_rd_data[OFS_CNT_LSB +: CW];
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + CW'(1);
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (handshake) state_d = ST_LOAD;
      ST_LOAD: begin
        if (abort)                                   state_d = ST_IDLE;
        else if (ofs_rd_data[OFS_CNT_LSB +: CW] == '0) state_d = ST_DONE;
        else                                         state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (abort)                  state_d = ST_IDLE;
        else if (pop && edge_last)  state_d = ST_DONE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_edge_fetch_ctrl.sv
// Directed bench for edge_fetch_ctrl with behavioural offset/edge memories
// (1-cycle read latency) and hand-computed expected beats and cycle numbers.
module tb_edge_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_node_idx;
  logic        abort;
  logic        ofs_rd_en;
  logic [9:0]  ofs_addr;
  logic [15:0] ofs_rd_data;
  logic        edge_rd_en;
  logic [11:0] edge_addr;
  logic [9:0]  edge_rd_data;
  logic        edge_valid;
  logic        edge_ready;
  logic [9:0]  edge_node_idx;
  logic        edge_last;
  logic [3:0]  edge_count;
  logic        done;

  logic [15:0] ofs_mem  [1024];
  logic [9:0]  edge_mem [4096];

  int n_checks = 0;
  int n_fail   = 0;

  int got_idx[$];
  int got_last[$];
  int got_cyc[$];
  int addrs[$];
  int done_cyc, done_pulses, rd_cnt, first_valid, stall_bad;
  logic valid_hist [64];
  logic ready_hist [64];

  always #5 clk = ~clk;

  edge_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_node_idx  (req_node_idx),
    .abort         (abort),
    .ofs_rd_en     (ofs_rd_en),
    .ofs_addr      (ofs_addr),
    .ofs_rd_data   (ofs_rd_data),
    .edge_rd_en    (edge_rd_en),
    .edge_addr     (edge_addr),
    .edge_rd_data  (edge_rd_data),
    .edge_valid    (edge_valid),
    .edge_ready    (edge_ready),
    .edge_node_idx (edge_node_idx),
    .edge_last     (edge_last),
    .edge_count    (edge_count),
    .done          (done)
  );

  always @(posedge clk) begin
    if (ofs_rd_en)  ofs_rd_data  <= ofs_mem[ofs_addr];
    if (edge_rd_en) edge_rd_data <= edge_mem[edge_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One request from cycle 0 (handshake cycle); records every beat with its cycle.
  task automatic run_fetch(input int node, input int stall_lo, input int stall_hi,
                           input int abort_cyc, input int stop_cyc);
    bit   fin        = 1'b0;
    bit   prev_stall = 1'b0;
    int   prev_idx   = 0;
    logic prev_last  = 1'b0;
    got_idx.delete(); got_last.delete(); got_cyc.delete(); addrs.delete();
    done_cyc = -1; done_pulses = 0; rd_cnt = 0; first_valid = -1; stall_bad = 0;
    for (int i = 0; i < 64; i++) begin
      valid_hist[i] = 1'b0;
      ready_hist[i] = 1'b0;
    end
    for (int c = 0; c < 48 && !fin; c++) begin
      req_valid    = (c == 0);
      req_node_idx = 10'(node);
      edge_ready   = !(c >= stall_lo && c <= stall_hi);
      abort        = (c == abort_cyc);
      @(negedge clk);
      if (c == 0) begin
        check("hs_ofs_rd_en", 32'(ofs_rd_en), 1);
        check("hs_ofs_addr", 32'(ofs_addr), node);
      end
      valid_hist[c] = edge_valid;
      ready_hist[c] = req_ready;
      if (edge_rd_en) begin
        rd_cnt++;
        addrs.push_back(int'(edge_addr));
      end
      if (prev_stall && !(edge_valid && int'(edge_node_idx) == prev_idx && edge_last == prev_last))
        stall_bad++;
      prev_stall = edge_valid && !edge_ready;
      prev_idx   = int'(edge_node_idx);
      prev_last  = edge_last;
      if (edge_valid && first_valid < 0) first_valid = c;
      if (edge_valid && edge_ready && !abort) begin
        got_idx.push_back(int'(edge_node_idx));
        got_last.push_back(int'(edge_last));
        got_cyc.push_back(c);
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if ((done_cyc >= 0 && c == done_cyc + 1) ||
          (abort_cyc >= 0 && c == abort_cyc + 2) || c == stop_cyc)
        fin = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    abort      = 1'b0;
    edge_ready = 1'b1;
    check("run_completed_in_budget", 32'(fin), 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"},     32'(req_ready), 1);
    check({pfx, "_edge_valid"},    32'(edge_valid), 0);
    check({pfx, "_edge_last"},     32'(edge_last), 0);
    check({pfx, "_done"},          32'(done), 0);
    check({pfx, "_ofs_rd_en"},     32'(ofs_rd_en), 0);
    check({pfx, "_edge_rd_en"},    32'(edge_rd_en), 0);
    check({pfx, "_edge_count"},    32'(edge_count), 0);
    check({pfx, "_edge_node_idx"}, 32'(edge_node_idx), 0);
    check({pfx, "_edge_addr"},     32'(edge_addr), 0);
    check({pfx, "_ofs_addr"},      32'(ofs_addr), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ofs_mem[i] = '0;
    for (int i = 0; i < 4096; i++) edge_mem[i] = '0;
    ofs_mem[5] = {12'h010, 4'd3};
    ofs_mem[6] = {12'h020, 4'd0};
    ofs_mem[7] = {12'hFFE, 4'd4};
    ofs_mem[8] = {12'h030, 4'd2};
    edge_mem[12'h010] = 10'd7;
    edge_mem[12'h011] = 10'd9;
    edge_mem[12'h012] = 10'd12;
    edge_mem[12'hFFE] = 10'd1;
    edge_mem[12'hFFF] = 10'd2;
    edge_mem[12'h000] = 10'd3;
    edge_mem[12'h001] = 10'd4;
    edge_mem[12'h030] = 10'd100;
    edge_mem[12'h031] = 10'd200;
    ofs_rd_data  = '0;
    edge_rd_data = '0;

    rst_n = 1'b0; req_valid = 1'b0; req_node_idx = '0; abort = 1'b0; edge_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three edges, consumer always ready.
    run_fetch(5, 99, 99, -1, -1);
    check("a_num_edges", 32'(got_idx.size()), 3);
    if (got_idx.size() == 3) begin
      check("a_e0", got_idx[0], 7);   check("a_c0", got_cyc[0], 4);  check("a_l0", got_last[0], 0);
      check("a_e1", got_idx[1], 9);   check("a_c1", got_cyc[1], 5);  check("a_l1", got_last[1], 0);
      check("a_e2", got_idx[2], 12);  check("a_c2", got_cyc[2], 6);  check("a_l2", got_last[2], 1);
    end
    check("a_ready_cyc1", 32'(ready_hist[1]), 0);
    check("a_done_cyc", done_cyc, 7);
    check("a_done_pulses", done_pulses, 1);
    check("a_ready_cyc8", 32'(ready_hist[8]), 1);
    check("a_edge_count", 32'(edge_count), 3);

    // Zero-edge node.
    run_fetch(6, 99, 99, -1, -1);
    check("b_first_valid", first_valid, -1);
    check("b_rd_cnt", rd_cnt, 0);
    check("b_done_cyc", done_cyc, 2);
    check("b_edge_count", 32'(edge_count), 0);

    // Consumer stalled in cycles 4..7.
    run_fetch(5, 4, 7, -1, -1);
    check("c_stall_stable", stall_bad, 0);
    check("c_rd_cnt", rd_cnt, 3);
    check("c_num_edges", 32'(got_idx.size()), 3);
    if (got_idx.size() == 3) begin
      check("c_e0", got_idx[0], 7);   check("c_c0", got_cyc[0], 8);
      check("c_e1", got_idx[1], 9);   check("c_c1", got_cyc[1], 9);
      check("c_e2", got_idx[2], 12);  check("c_c2", got_cyc[2], 10);
      check("c_l2", got_last[2], 1);
    end
    check("c_done_cyc", done_cyc, 11);

    // Edge address wraps past the top of edge memory.
    run_fetch(7, 99, 99, -1, -1);
    check("d_num_addrs", 32'(addrs.size()), 4);
    if (addrs.size() == 4) begin
      check("d_a0", addrs[0], 12'hFFE); check("d_a1", addrs[1], 12'hFFF);
      check("d_a2", addrs[2], 12'h000); check("d_a3", addrs[3], 12'h001);
    end
    check("d_num_edges", 32'(got_idx.size()), 4);
    if (got_idx.size() == 4) begin
      check("d_e2", got_idx[2], 3);
      check("d_l2", got_last[2], 0);
      check("d_e3", got_idx[3], 4);
      check("d_l3", got_last[3], 1);
    end
    check("d_done_cyc", done_cyc, 8);

    // Abort one cycle after the first edge is accepted, then a fresh node.
    run_fetch(5, 99, 99, 5, -1);
    check("e_num_edges", 32'(got_idx.size()), 1);
    if (got_idx.size() == 1) check("e_e0", got_idx[0], 7);
    check("e_valid_after_abort", 32'(valid_hist[6]), 0);
    check("e_no_done", done_pulses, 0);
    check("e_ready_after_abort", 32'(ready_hist[6]), 1);
    run_fetch(8, 99, 99, -1, -1);
    check("f_num_edges", 32'(got_idx.size()), 2);
    if (got_idx.size() == 2) begin
      check("f_e0", got_idx[0], 100);
      check("f_e1", got_idx[1], 200);
      check("f_l1", got_last[1], 1);
    end
    check("f_done_cyc", done_cyc, 6);

    // Reset pulsed mid-stream, then a full request.
    run_fetch(5, 99, 99, -1, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_fetch(8, 99, 99, -1, -1);
    check("g_num_edges", 32'(got_idx.size()), 2);
    if (got_idx.size() == 2) begin
      check("g_e0", got_idx[0], 100);
      check("g_c0", got_cyc[0], 4);
      check("g_e1", got_idx[1], 200);
    end
    check("g_done_cyc", done_cyc, 6);
    check("g_edge_count", 32'(edge_count), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_fetch_ctrl.md
EDGE_FETCH_CTRL -- requirements
Module: edge_fetch_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  PARAM_NODE_IDX_WIDTH  10  node index width
  PARAM_COUNTER_WIDTH   4   per-node edge count width
  PARAM_EDGE_ADDR_WIDTH 12  edge memory address width
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  req_valid  in  1  node fetch request
  req_ready  out  1  controller idle, can accept a request
  req_node_idx  in  NODE_IDX  node whose out-edges are fetched
  abort  in  1  synchronous cancel of the current fetch
  ofs_rd_en  out  1  offset table read strobe
  ofs_addr  out  NODE_IDX  offset table address
  ofs_rd_data  in  EDGE_ADDR+COUNTER  {edge_base, edge_cnt}, 1-cycle read latency
  edge_rd_en  out  1  edge memory read strobe
  edge_addr  out  EDGE_ADDR  edge memory address
  edge_rd_data  in  NODE_IDX  neighbour index, 1-cycle read latency
  edge_valid  out  1  neighbour available
  edge_ready  in  1  consumer accepts neighbour
  edge_node_idx  out  NODE_IDX  neighbour index
  edge_last  out  1  final neighbour of the current node
  edge_count  out  COUNTER  edge count of the current node
  done  out  1  one-cycle pulse, fetch complete

Function
REQ-003 States: IDLE, LOAD, STREAM, DONE.
REQ-004 req_ready is 1 only in IDLE. A handshake (req_valid&req_ready) at cycle 0 drives ofs_rd_en=1 and ofs_addr=req_node_idx combinationally in cycle 0; the state then moves to LOAD.
REQ-005 LOAD (cycle 1) captures edge_base and edge_cnt into registers. If edge_cnt==0, next is DONE; otherwise next is STREAM.
REQ-006 STREAM issues edge_rd_en with edge_addr=edge_base+issued. Addition is modulo 2^EDGE_ADDR_WIDTH, so it wraps.
REQ-007 A read is issued only when buffer occupancy plus in-flight reads is less than 2, and never beyond edge_cnt total reads.
REQ-008 edge_rd_data is written into a 2-entry in-order output buffer in the cycle after its read. edge_valid is 1 whenever the buffer is non-empty.
REQ-009 First edge_valid occurs at cycle 4. With edge_ready held at 1, edges stream at 1 per cycle.
REQ-010 While edge_valid=1 and edge_ready=0, edge_node_idx and edge_last remain stable.
REQ-011 edge_last=1 exactly on the edge_cnt-th neighbour.
REQ-012 Acceptance of the edge_last beat moves the state to DONE.
REQ-013 DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-014 edge_count holds the captured edge_cnt from LOAD until the next LOAD. It reads 0 after reset.
REQ-015 abort=1 in any non-IDLE state:
  - the next state is IDLE;
  - the buffer is flushed and edge_valid=0 from the next cycle;
  - in-flight read data is discarded;
  - done is not pulsed.
  abort in IDLE has no effect.
REQ-016 req_valid while not IDLE is ignored, with no queuing.
REQ-017 When abort and edge acceptance occur in the same cycle, abort wins.

Reset
REQ-018 While rst_n=0, the state is IDLE and the buffer and in-flight flag are cleared.
REQ-019 While rst_n=0, outputs are: req_ready=1; edge_valid, edge_last, done, ofs_rd_en and edge_rd_en =0; edge_count, edge_node_idx, edge_addr and ofs_addr =0.
REQ-020 Reset asserted mid-stream discards all pending data. The first request after deassertion is served per REQ-004..013.

Structure
REQ-021 A shared package holds:
  - the parameter defaults;
  - the state encoding;
  - the ofs_rd_data field widths and positions (edge_base in the upper bits, edge_cnt in the lower bits).
REQ-022 A single sub-module, edge_skid_buf, implements the 2-entry buffer with push, pop, flush and occupancy.

Verification
REQ-023 Node 5 with ofs {0x010,3} and mem[0x10..0x12]=7,9,12, edge_ready=1 -> edges 7,9,12 at cycles 4,5,6 with edge_last on 12; done at cycle 7; req_ready=1 at cycle 8.
REQ-024 ofs {0x020,0} -> no edge_valid, edge_count=0, done at cycle 2.
REQ-025 Case of REQ-023 with edge_ready=0 in cycles 4-7 -> 7 held stable; edge_rd_en asserted at most 3 times total; order 7,9,12 preserved; done one cycle after 12 is accepted.
REQ-026 ofs {0xFFE,4} -> edge_addr sequence 0xFFE,0xFFF,0x000,0x001.
REQ-027 abort one cycle after the first edge is accepted -> edge_valid=0 next cycle, no done; a following request for a different node returns only that node's edges.
REQ-028 rst_n pulsed low during STREAM -> outputs match REQ-019; a subsequent request completes correctly.
